// File: rtl/local_history_predictor.sv
// rtl/local_history_predictor.sv - two-level local-history (PAs) direction predictor with init sweep
// Optional saturating statistics counters are built when PRED_STATS_EN is defined.
module local_history_predictor #(
    parameter int FETCH_W   = 2,
    parameter int UPD_W     = 2,
    parameter int PC_W      = 32,
    parameter int INSN_SH   = 2,
    parameter int BHT_IDX_W = 8,
    parameter int HIST_LEN  = 6,
    parameter int SET_BITS  = 2,
    parameter int CTR_W     = 2
) (
    input  logic                         clk,
    input  logic                         rstN,
    output logic                         ready,
    input  logic                         stall,
    input  logic                         flush,
    input  logic [FETCH_W-1:0]           lk_valid,
    input  logic [PC_W-1:0]              lk_pc,
    input  logic [FETCH_W-1:0]           lk_is_cond,
    output logic [FETCH_W-1:0]           pr_valid,
    output logic [FETCH_W-1:0]           pr_taken,
    output logic [FETCH_W*HIST_LEN-1:0]  pr_hist,
    output logic [FETCH_W*CTR_W-1:0]     pr_ctr,
    input  logic [UPD_W-1:0]             up_valid,
    input  logic [UPD_W*PC_W-1:0]        up_pc,
    input  logic [UPD_W*HIST_LEN-1:0]    up_hist,
    input  logic [UPD_W*CTR_W-1:0]       up_ctr,
    input  logic [UPD_W-1:0]             up_taken,
    input  logic [UPD_W-1:0]             up_mispred,
    input  logic [UPD_W-1:0]             up_is_cond,
    output logic [31:0]                  st_lookups,
    output logic [31:0]                  st_mispred,
    output logic [31:0]                  st_drops
);
    localparam int PHT_IDX_W = SET_BITS + HIST_LEN;
    localparam int BHT_N     = 1 << BHT_IDX_W;
    localparam int PHT_N     = 1 << PHT_IDX_W;
    localparam int CNT_W     = (BHT_IDX_W > PHT_IDX_W) ? BHT_IDX_W : PHT_IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [0:0] INIT  = 1'b0;
    localparam logic [0:0] READY = 1'b1;

    logic [HIST_LEN-1:0] bht [BHT_N];
    logic [CTR_W-1:0]    pht [PHT_N];

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= INIT;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + CNT_W'(1);
            if (&cnt) state <= READY;
        end
    end

    assign ready = (state == READY);

    // Lookup: tables read combinationally, so a same-cycle write is not visible
    logic [FETCH_W-1:0][PC_W-1:0]      lkPc;
    logic [FETCH_W-1:0][BHT_IDX_W-1:0] lkBhtIdx;
    logic [FETCH_W-1:0][HIST_LEN-1:0]  lkHist;
    logic [FETCH_W-1:0][CTR_W-1:0]     lkCtr;

    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            lkPc[i]     = lk_pc + (PC_W'(i) << INSN_SH);
            lkBhtIdx[i] = lkPc[i][INSN_SH +: BHT_IDX_W];
            lkHist[i]   = bht[lkBhtIdx[i]];
            lkCtr[i]    = pht[{lkPc[i][INSN_SH +: SET_BITS], lkHist[i]}];
        end
    end

    logic [FETCH_W-1:0][BHT_IDX_W-1:0] prIdx;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pr_valid <= '0;
            pr_taken <= '0;
            pr_hist  <= '0;
            pr_ctr   <= '0;
            prIdx    <= '0;
        end else if (!ready) begin
            pr_valid <= '0;
        end else if (!stall) begin
            for (int i = 0; i < FETCH_W; i++) begin
                pr_valid[i]                       <= lk_valid[i];
                pr_taken[i]                       <= lkCtr[i][CTR_W-1];
                pr_hist[i*HIST_LEN +: HIST_LEN]   <= lkHist[i];
                pr_ctr[i*CTR_W +: CTR_W]          <= lkCtr[i];
                prIdx[i]                          <= lkBhtIdx[i];
            end
        end
    end

    // Resolve side: PHT training with lowest-lane-wins, and BHT repair
    logic                               recover;
    logic [UPD_W-1:0][PHT_IDX_W-1:0]    upPhtIdx;
    logic [UPD_W-1:0][BHT_IDX_W-1:0]    upBhtIdx;
    logic [UPD_W-1:0][CTR_W-1:0]        newCtr;
    logic [UPD_W-1:0][HIST_LEN-1:0]     recVal;
    logic [UPD_W-1:0]                   phtWe, phtDrop, recWe;

    assign recover = ready && |(up_valid & up_mispred & up_is_cond);

    always_comb begin
        logic [CTR_W-1:0] upCtr;
        upCtr   = '0;
        phtWe   = '0;
        phtDrop = '0;
        recWe   = '0;
        for (int u = 0; u < UPD_W; u++) begin
            upPhtIdx[u] = {up_pc[u*PC_W+INSN_SH +: SET_BITS], up_hist[u*HIST_LEN +: HIST_LEN]};
            upBhtIdx[u] = up_pc[u*PC_W+INSN_SH +: BHT_IDX_W];
            recVal[u]   = {up_hist[u*HIST_LEN +: HIST_LEN-1], up_taken[u]};
            upCtr       = up_ctr[u*CTR_W +: CTR_W];
            if (up_taken[u]) newCtr[u] = (upCtr == CTR_MAX) ? upCtr : upCtr + CTR_W'(1);
            else             newCtr[u] = (upCtr == '0)      ? upCtr : upCtr - CTR_W'(1);
        end
        for (int u = 0; u < UPD_W; u++) begin
            if (ready && up_valid[u] && up_is_cond[u]) begin
                phtWe[u] = 1'b1;
                for (int k = 0; k < u; k++)
                    if (up_valid[k] && up_is_cond[k] && upPhtIdx[k] == upPhtIdx[u]) begin
                        phtWe[u]   = 1'b0;
                        phtDrop[u] = 1'b1;
                    end
            end
            if (ready && up_valid[u] && up_mispred[u] && up_is_cond[u]) begin
                recWe[u] = 1'b1;
                for (int k = 0; k < u; k++)
                    if (recWe[k] && upBhtIdx[k] == upBhtIdx[u]) recWe[u] = 1'b0;
            end
        end
    end

    // Speculative shift in the response cycle; same-index lanes chain onto the earlier result
    logic [FETCH_W-1:0]                specWe;
    logic [FETCH_W-1:0][HIST_LEN-1:0]  specVal;

    always_comb begin
        logic [HIST_LEN-1:0] base;
        logic                stop;
        base   = '0;
        stop   = 1'b0;
        specWe = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            base = pr_hist[i*HIST_LEN +: HIST_LEN];
            for (int j = 0; j < i; j++)
                if (specWe[j] && prIdx[j] == prIdx[i]) base = specVal[j];
            specVal[i] = {base[HIST_LEN-2:0], pr_taken[i]};
            if (!stop && pr_valid[i] && lk_is_cond[i] && !flush && !stall && !recover) begin
                specWe[i] = 1'b1;
                stop      = pr_taken[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            if (32'(cnt) < BHT_N) bht[cnt[BHT_IDX_W-1:0]] <= '0;
            if (32'(cnt) < PHT_N) pht[cnt[PHT_IDX_W-1:0]] <= CTR_INIT;
        end else begin
            for (int i = 0; i < FETCH_W; i++)
                if (specWe[i]) bht[prIdx[i]] <= specVal[i];
            for (int u = 0; u < UPD_W; u++)
                if (phtWe[u]) pht[upPhtIdx[u]] <= newCtr[u];
            for (int u = 0; u < UPD_W; u++)
                if (recWe[u]) bht[upBhtIdx[u]] <= recVal[u];
        end
    end

`ifdef PRED_STATS_EN
    function automatic logic [31:0] satAdd(input logic [31:0] a, input int n);
        logic [32:0] s;
        s = {1'b0, a} + 33'(n);
        return s[32] ? 32'hffff_ffff : s[31:0];
    endfunction

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            st_lookups <= '0;
            st_mispred <= '0;
            st_drops   <= '0;
        end else if (ready) begin
            st_lookups <= satAdd(st_lookups, stall ? 0 : $countones(lk_valid));
            st_mispred <= satAdd(st_mispred, $countones(up_valid & up_mispred));
            st_drops   <= satAdd(st_drops, $countones(phtDrop));
        end
    end
`else
    assign st_lookups = '0;
    assign st_mispred = '0;
    assign st_drops   = '0;
`endif

    logic unusedBits;
    assign unusedBits = ^{lkPc, up_pc, phtDrop};

endmodule

// File: tb/tb_local_history_predictor.sv
// tb/tb_local_history_predictor.sv - randomized and directed bench against a table-level reference model
module tb_local_history_predictor;
    localparam int FW = 2, UW = 2, PCW = 32, SH = 2, BI = 10, HL = 6, SB = 2, CW = 2;
    localparam int BHT_N    = 1 << BI;
    localparam int PHT_N    = 1 << (SB + HL);
    localparam int INIT_CYC = (BHT_N > PHT_N) ? BHT_N : PHT_N;
    localparam int CTR_TOP  = (1 << CW) - 1;

    logic clk = 0, rstN = 0, ready, stall = 0, flush = 0;
    logic [FW-1:0]    lk_valid = '0, lk_is_cond = '0, pr_valid, pr_taken;
    logic [PCW-1:0]   lk_pc = '0;
    logic [FW*HL-1:0] pr_hist;
    logic [FW*CW-1:0] pr_ctr;
    logic [UW-1:0]    up_valid = '0, up_taken = '0, up_mispred = '0, up_is_cond = '0;
    logic [UW*PCW-1:0] up_pc = '0;
    logic [UW*HL-1:0]  up_hist = '0;
    logic [UW*CW-1:0]  up_ctr = '0;
    logic [31:0] st_lookups, st_mispred, st_drops;

    local_history_predictor #(.FETCH_W(FW), .UPD_W(UW), .PC_W(PCW), .INSN_SH(SH), .BHT_IDX_W(BI),
                              .HIST_LEN(HL), .SET_BITS(SB), .CTR_W(CW)) dut (
        .clk(clk), .rstN(rstN), .ready(ready), .stall(stall), .flush(flush),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_is_cond(lk_is_cond),
        .pr_valid(pr_valid), .pr_taken(pr_taken), .pr_hist(pr_hist), .pr_ctr(pr_ctr),
        .up_valid(up_valid), .up_pc(up_pc), .up_hist(up_hist), .up_ctr(up_ctr),
        .up_taken(up_taken), .up_mispred(up_mispred), .up_is_cond(up_is_cond),
        .st_lookups(st_lookups), .st_mispred(st_mispred), .st_drops(st_drops));

    always #5 clk = ~clk;

    int nCmp = 0, nFail = 0;
    int bhtM [BHT_N];
    int phtM [PHT_N];
    int lookupsM = 0, mispredM = 0, dropsM = 0;
    int predIdx [FW];
    int predTaken [FW];
    int predValid [FW];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bhtIdx(input logic [31:0] pc);
        return int'((pc >> SH) % BHT_N);
    endfunction

    function automatic int phtIdx(input logic [31:0] pc, input int h);
        return int'((pc >> SH) % (1 << SB)) * (1 << HL) + h;
    endfunction

    function automatic int shiftIn(input int h, input int t);
        return (h * 2 + t) % (1 << HL);
    endfunction

    task automatic modelInit();
        for (int i = 0; i < BHT_N; i++) bhtM[i] = 0;
        for (int i = 0; i < PHT_N; i++) phtM[i] = 1 << (CW - 1);
        for (int i = 0; i < FW; i++) predValid[i] = 0;
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        check(tag, n, INIT_CYC);
    endtask

    task automatic issue(input logic [FW-1:0] v, input logic [31:0] pc);
        lk_valid = v; lk_pc = pc; lk_is_cond = '0;
        tick();
        lk_valid = '0;
        check("pr_valid", pr_valid, v);
        for (int i = 0; i < FW; i++) begin
            logic [31:0] lpc;
            int h, c;
            lpc = pc + 32'(i * (1 << SH));
            predIdx[i]   = bhtIdx(lpc);
            h            = bhtM[predIdx[i]];
            c            = phtM[phtIdx(lpc, h)];
            predValid[i] = v[i];
            predTaken[i] = (c >= (1 << (CW - 1))) ? 1 : 0;
            if (v[i]) begin
                check("pr_hist", pr_hist[i*HL +: HL], h);
                check("pr_ctr", pr_ctr[i*CW +: CW], c);
                check("pr_taken", pr_taken[i], predTaken[i]);
            end
        end
        lookupsM += $countones(v);
    endtask

    task automatic setUp(input int u, input logic [31:0] pc, input int h, input int c,
                         input bit t, input bit m, input bit cnd);
        up_valid[u] = 1'b1;
        up_pc[u*PCW +: PCW] = pc;
        up_hist[u*HL +: HL] = HL'(h);
        up_ctr[u*CW +: CW]  = CW'(c);
        up_taken[u] = t; up_mispred[u] = m; up_is_cond[u] = cnd;
    endtask

    task automatic respond(input logic [FW-1:0] cond, input logic fl);
        int anyRec;
        lk_is_cond = cond; flush = fl;
        tick();
        anyRec = 0;
        for (int u = 0; u < UW; u++) begin
            if (up_valid[u] && up_is_cond[u]) begin
                int idx, c, dup;
                idx = phtIdx(up_pc[u*PCW +: PCW], int'(up_hist[u*HL +: HL]));
                dup = 0;
                for (int k = 0; k < u; k++)
                    if (up_valid[k] && up_is_cond[k] &&
                        phtIdx(up_pc[k*PCW +: PCW], int'(up_hist[k*HL +: HL])) == idx) dup = 1;
                if (dup) dropsM++;
                else begin
                    c = int'(up_ctr[u*CW +: CW]);
                    c = up_taken[u] ? ((c < CTR_TOP) ? c + 1 : c) : ((c > 0) ? c - 1 : c);
                    phtM[idx] = c;
                end
            end
            if (up_valid[u] && up_mispred[u]) mispredM++;
        end
        for (int u = UW - 1; u >= 0; u--)
            if (up_valid[u] && up_mispred[u] && up_is_cond[u]) begin
                bhtM[bhtIdx(up_pc[u*PCW +: PCW])] = shiftIn(int'(up_hist[u*HL +: HL]), int'(up_taken[u]));
                anyRec = 1;
            end
        if (!fl && anyRec == 0)
            for (int i = 0; i < FW; i++)
                if (predValid[i] != 0 && cond[i]) begin
                    bhtM[predIdx[i]] = shiftIn(bhtM[predIdx[i]], predTaken[i]);
                    if (predTaken[i] != 0) break;
                end
        for (int i = 0; i < FW; i++) predValid[i] = 0;
        up_valid = '0; up_mispred = '0; up_is_cond = '0; up_taken = '0;
        lk_is_cond = '0; flush = 0;
    endtask

    initial begin
        modelInit();
        repeat (3) tick();
        check("reset_ready", ready, 0);
        check("reset_pr_valid", pr_valid, 0);
        check("reset_st_lookups", st_lookups, 0);
        rstN = 1;
        waitReady("init_cycles");

        issue(2'b11, 32'h100);
        check("init_ctr_l0", pr_ctr[CW-1:0], 2);
        check("init_taken", pr_taken, 2'b11);
        respond(2'b00, 0);

        setUp(0, 32'h100, 0, 2, 0, 0, 1); respond(2'b00, 0);
        issue(2'b01, 32'h100); check("ctr_nt1", pr_ctr[CW-1:0], 1); respond(2'b00, 0);
        setUp(0, 32'h100, 0, 1, 0, 0, 1); respond(2'b00, 0);
        issue(2'b01, 32'h100); check("ctr_nt2", pr_ctr[CW-1:0], 0); respond(2'b00, 0);
        setUp(0, 32'h100, 0, 0, 0, 0, 1); respond(2'b00, 0);
        issue(2'b01, 32'h100); check("ctr_sat_lo", pr_ctr[CW-1:0], 0); respond(2'b00, 0);
        setUp(0, 32'h100, 0, 3, 1, 0, 1); respond(2'b00, 0);
        issue(2'b01, 32'h100); check("ctr_sat_hi", pr_ctr[CW-1:0], 3); respond(2'b00, 0);

        issue(2'b11, 32'h200); respond(2'b11, 0);
        issue(2'b11, 32'h200);
        check("spec_lane0", pr_hist[HL-1:0], 1);
        check("spec_lane1", pr_hist[2*HL-1:HL], 0);
        respond(2'b00, 0);

        setUp(0, 32'h300, 2, 1, 1, 1, 1); respond(2'b00, 0);
        setUp(0, 32'h300, 5, 0, 1, 0, 1);
        setUp(1, 32'h300, 5, 3, 1, 0, 1);
        respond(2'b00, 0);
        issue(2'b01, 32'h300);
        check("drop_hist", pr_hist[HL-1:0], 5);
        check("drop_ctr", pr_ctr[CW-1:0], 1);
        respond(2'b00, 0);
`ifdef PRED_STATS_EN
        check("st_drops_one", st_drops, 1);
`else
        check("st_drops_off", st_drops, 0);
`endif

        issue(2'b01, 32'h400);
        setUp(0, 32'h400, 6'b101010, 2, 1, 1, 1);
        respond(2'b01, 0);
        issue(2'b01, 32'h400);
        check("recover_hist", pr_hist[HL-1:0], 6'b010101);
        respond(2'b00, 0);

        issue(2'b01, 32'h500);
        stall = 1; lk_valid = 2'b11; lk_pc = 32'h600;
        tick();
        check("stall_valid", pr_valid, 2'b01);
        check("stall_hist", pr_hist[HL-1:0], bhtM[predIdx[0]]);
        stall = 0; lk_valid = '0;
        respond(2'b00, 0);

        for (int it = 0; it < 300; it++) begin
            logic [31:0] pc;
            pc = 32'h1000 + ($urandom_range(0, 7) << SH);
            issue(FW'($urandom_range(0, 3)), pc);
            for (int u = 0; u < UW; u++)
                if ($urandom_range(0, 1) == 1)
                    setUp(u, 32'h1000 + ($urandom_range(0, 7) << SH), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
            respond(FW'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end
        check("ready_held", ready, 1);

`ifdef PRED_STATS_EN
        check("st_lookups", st_lookups, lookupsM);
        check("st_mispred", st_mispred, mispredM);
        check("st_drops", st_drops, dropsM);
`else
        check("st_lookups_off", st_lookups, 0);
        check("st_mispred_off", st_mispred, 0);
        check("st_drops_off2", st_drops, 0);
`endif

        rstN = 0; tick(); rstN = 1;
        repeat (500) tick();
        check("mid_init_ready", ready, 0);
        rstN = 0; tick();
        check("rereset_ready", ready, 0);
        check("rereset_st", st_lookups, 0);
        rstN = 1;
        waitReady("reinit_cycles");
        modelInit();
        issue(2'b11, 32'h400);
        check("reinit_hist", pr_hist[HL-1:0], 0);
        check("reinit_ctr", pr_ctr[CW-1:0], 2);
        respond(2'b00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
